// File: rtl/ts_header_monitor.sv
// rtl/ts_header_monitor.sv - TS packet header parser with continuity supervision and QoS counters
module ts_header_monitor #(
    parameter int CNT_W   = 16,
    parameter int PKT_LEN = 188
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             sync_in,
    input  logic [12:0]      mon_pid,
    input  logic             clr_cnt,
    output logic             hdr_valid,
    output logic [12:0]      pid,
    output logic             tei,
    output logic             pusi,
    output logic [1:0]       afc,
    output logic [3:0]       cc,
    output logic             cc_err,
    output logic             sync_lost,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] tei_cnt,
    output logic [CNT_W-1:0] cc_err_cnt,
    output logic [CNT_W-1:0] loss_cnt
);
    localparam int               IDX_W    = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [12:0]      NULL_PID = 13'h1FFF;

    // State names the byte expected next: HDR1 consumes byte 1, EXPECT the next sync byte.
    typedef enum logic [2:0] {
        IDLE, HDR1, HDR2, HDR3, AFLEN, AFFLG, BODY, EXPECT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [4:0]       pid_hi;
    logic [7:0]       pid_lo;
    logic             tei_acc;
    logic             pusi_acc;
    logic [7:0]       af_len;
    logic [12:0]      mon_pid_s;
    logic [3:0]       cc_ref;
    logic             cc_ref_vld;
    logic             dup_seen;

    logic             in_pkt;
    logic             restart;
    logic             hdr_evt;
    logic             loss_evt;
    logic             cc_evt;
    logic             cc_chk;
    logic             disc;
    logic             cc_bad;
    logic             dup_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Continuity verdict for the current packet, valid while byte 5 is presented.
    always_comb begin
        cc_chk   = (pid == mon_pid_s) && (pid != NULL_PID);
        disc     = afc[1] & (af_len != 8'd0) & byte_in[7];
        cc_bad   = 1'b0;
        dup_next = dup_seen;
        if (!cc_ref_vld || disc) begin
            dup_next = 1'b0;
        end else if (!afc[0]) begin
            cc_bad = (cc != cc_ref);
        end else if (cc == cc_ref + 4'd1) begin
            dup_next = 1'b0;
        end else if (cc == cc_ref) begin
            cc_bad   = dup_seen;
            dup_next = 1'b1;
        end else begin
            cc_bad   = 1'b1;
            dup_next = 1'b0;
        end
    end

    // Event strobes shared by the parser and the statistics counters.
    always_comb begin
        in_pkt   = (state != IDLE) && (state != EXPECT);
        restart  = byte_valid && sync_in && in_pkt;
        hdr_evt  = byte_valid && !sync_in && (state == HDR3);
        cc_evt   = byte_valid && !sync_in && (state == AFFLG) && cc_chk && cc_bad;
        loss_evt = restart || (byte_valid && !sync_in && (state == EXPECT));
    end

    // Packet framing FSM with header field capture and CC reference tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            pid_hi     <= '0;
            pid_lo     <= '0;
            tei_acc    <= 1'b0;
            pusi_acc   <= 1'b0;
            af_len     <= '0;
            mon_pid_s  <= '0;
            cc_ref     <= '0;
            cc_ref_vld <= 1'b0;
            dup_seen   <= 1'b0;
            hdr_valid  <= 1'b0;
            pid        <= '0;
            tei        <= 1'b0;
            pusi       <= 1'b0;
            afc        <= '0;
            cc         <= '0;
            cc_err     <= 1'b0;
            sync_lost  <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            cc_err    <= 1'b0;
            sync_lost <= 1'b0;
            if (byte_valid) begin
                idx <= idx + IDX_W'(1);
                if (restart) begin
                    state     <= HDR1;
                    idx       <= IDX_W'(1);
                    sync_lost <= 1'b1;
                end else begin
                    case (state)
                        IDLE: begin
                            idx <= '0;
                            if (sync_in) begin
                                state <= HDR1;
                                idx   <= IDX_W'(1);
                            end
                        end
                        HDR1: begin
                            tei_acc  <= byte_in[7];
                            pusi_acc <= byte_in[6];
                            pid_hi   <= byte_in[4:0];
                            state    <= HDR2;
                        end
                        HDR2: begin
                            pid_lo    <= byte_in;
                            mon_pid_s <= mon_pid;
                            if (mon_pid != mon_pid_s) begin
                                cc_ref_vld <= 1'b0;
                                dup_seen   <= 1'b0;
                            end
                            state <= HDR3;
                        end
                        HDR3: begin
                            pid       <= {pid_hi, pid_lo};
                            tei       <= tei_acc;
                            pusi      <= pusi_acc;
                            afc       <= byte_in[5:4];
                            cc        <= byte_in[3:0];
                            hdr_valid <= 1'b1;
                            state     <= AFLEN;
                        end
                        AFLEN: begin
                            af_len <= byte_in;
                            state  <= AFFLG;
                        end
                        AFFLG: begin
                            if (cc_chk) begin
                                cc_err     <= cc_bad;
                                cc_ref     <= cc;
                                cc_ref_vld <= 1'b1;
                                dup_seen   <= dup_next;
                            end
                            state <= BODY;
                        end
                        BODY: begin
                            if (idx == LAST_IDX) begin
                                state <= EXPECT;
                                idx   <= '0;
                            end
                        end
                        EXPECT: begin
                            if (sync_in) begin
                                state <= HDR1;
                                idx   <= IDX_W'(1);
                            end else begin
                                state     <= IDLE;
                                idx       <= '0;
                                sync_lost <= 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            idx   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Saturating QoS counters; a clear request overrides any same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt    <= '0;
            tei_cnt    <= '0;
            cc_err_cnt <= '0;
            loss_cnt   <= '0;
        end else if (clr_cnt) begin
            pkt_cnt    <= '0;
            tei_cnt    <= '0;
            cc_err_cnt <= '0;
            loss_cnt   <= '0;
        end else begin
            if (hdr_evt)            pkt_cnt    <= sat_inc(pkt_cnt);
            if (hdr_evt && tei_acc) tei_cnt    <= sat_inc(tei_cnt);
            if (cc_evt)             cc_err_cnt <= sat_inc(cc_err_cnt);
            if (loss_evt)           loss_cnt   <= sat_inc(loss_cnt);
        end
    end

endmodule

// File: tb/tb_ts_header_monitor.sv
// tb/tb_ts_header_monitor.sv - scoreboard bench for ts_header_monitor
module tb_ts_header_monitor;
    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       byte_in = '0;
    logic             byte_valid = 1'b0;
    logic             sync_in = 1'b0;
    logic [12:0]      mon_pid = 13'h100;
    logic             clr_cnt = 1'b0;
    logic             hdr_valid;
    logic [12:0]      pid;
    logic             tei;
    logic             pusi;
    logic [1:0]       afc;
    logic [3:0]       cc;
    logic             cc_err;
    logic             sync_lost;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] tei_cnt;
    logic [CNT_W-1:0] cc_err_cnt;
    logic [CNT_W-1:0] loss_cnt;

    ts_header_monitor #(.CNT_W(CNT_W), .PKT_LEN(188)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .sync_in    (sync_in),
        .mon_pid    (mon_pid),
        .clr_cnt    (clr_cnt),
        .hdr_valid  (hdr_valid),
        .pid        (pid),
        .tei        (tei),
        .pusi       (pusi),
        .afc        (afc),
        .cc         (cc),
        .cc_err     (cc_err),
        .sync_lost  (sync_lost),
        .pkt_cnt    (pkt_cnt),
        .tei_cnt    (tei_cnt),
        .cc_err_cnt (cc_err_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [20:0] exp_hdr[$];
    int          exp_cc[$];
    int          hdr_seen = 0;
    int          tb_sent  = 0;
    int          exp_pkt = 0, exp_tei = 0, exp_ccerr = 0, exp_loss = 0;
    bit          gap = 1'b0;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Scoreboard side: pop expectations whenever the DUT reports a header or a CC error.
    initial begin
        forever begin
            @(negedge clk);
            if (hdr_valid) begin
                hdr_seen++;
                chk("hdr_expected", 32'(exp_hdr.size() != 0), 32'd1);
                if (exp_hdr.size() != 0)
                    chk("hdr_fields", 32'({pid, tei, pusi, afc, cc}), 32'(exp_hdr.pop_front()));
            end
            if (cc_err) begin
                chk("cc_err_expected", 32'(exp_cc.size() != 0), 32'd1);
                if (exp_cc.size() != 0)
                    chk("cc_err_pkt", 32'(hdr_seen), 32'(exp_cc.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic s, input logic c);
        @(negedge clk);
        byte_in = b; byte_valid = 1'b1; sync_in = s; clr_cnt = c;
        if (gap) begin
            @(negedge clk);
            byte_in = 8'($urandom); byte_valid = 1'b0; sync_in = 1'($urandom); clr_cnt = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0; sync_in = 1'b0; clr_cnt = 1'b0;
        end
    endtask

    task automatic send_pkt(input logic [12:0] p, input logic t, input logic [1:0] a,
                            input logic [3:0] c, input logic [7:0] afl, input logic [7:0] b5,
                            input bit err, input int n_bytes = 188, input int clr_at = -1);
        logic       pu;
        logic [7:0] v;
        pu = p[0] ^ c[0];
        if (n_bytes > 3) begin
            tb_sent++;
            exp_hdr.push_back({p, t, pu, a, c});
            exp_pkt = sat(exp_pkt);
            if (t) exp_tei = sat(exp_tei);
        end
        if (err && n_bytes > 5) begin
            exp_cc.push_back(tb_sent);
            exp_ccerr = sat(exp_ccerr);
        end
        for (int i = 0; i < n_bytes; i++) begin
            case (i)
                0:       v = 8'h47;
                1:       v = {t, pu, 1'b0, p[12:8]};
                2:       v = p[7:0];
                3:       v = {2'b00, a, c};
                4:       v = afl;
                5:       v = b5;
                default: v = 8'(i) ^ 8'h5A;
            endcase
            send_byte(v, i == 0, i == clr_at);
        end
        if (clr_at >= 0 && clr_at < n_bytes) begin
            exp_pkt = 0; exp_tei = 0; exp_ccerr = 0; exp_loss = 0;
        end
    endtask

    task automatic check_cnts(input string tag);
        chk({tag, "_pkt_cnt"},    32'(pkt_cnt),    32'(exp_pkt));
        chk({tag, "_tei_cnt"},    32'(tei_cnt),    32'(exp_tei));
        chk({tag, "_cc_err_cnt"}, 32'(cc_err_cnt), 32'(exp_ccerr));
        chk({tag, "_loss_cnt"},   32'(loss_cnt),   32'(exp_loss));
        chk({tag, "_cc_pending"}, 32'(exp_cc.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({hdr_valid, pid, tei, pusi, afc, cc, cc_err, sync_lost}), 32'd0);
        check_cnts("rst");
        rst = 1'b1;
        idle(2);

        // T1: clean packets on the monitored PID
        mon_pid = 13'h100;
        for (int k = 0; k < 3; k++) send_pkt(13'h100, 1'b0, 2'b01, 4'(k), 8'h00, 8'h00, 1'b0);
        idle(3);
        check_cnts("t1");

        // T2: skipped CC, then recovery
        mon_pid = 13'h200;
        send_pkt(13'h200, 1'b0, 2'b01, 4'd4, 8'h00, 8'h00, 1'b0);
        send_pkt(13'h200, 1'b0, 2'b01, 4'd5, 8'h00, 8'h00, 1'b0);
        send_pkt(13'h200, 1'b0, 2'b01, 4'd7, 8'h00, 8'h00, 1'b1);
        send_pkt(13'h200, 1'b0, 2'b01, 4'd8, 8'h00, 8'h00, 1'b0);
        idle(3);
        check_cnts("t2");

        // T3: duplicates and adaptation-only packets
        mon_pid = 13'h300;
        send_pkt(13'h300, 1'b0, 2'b01, 4'd3, 8'h00, 8'h00, 1'b0);
        send_pkt(13'h300, 1'b0, 2'b01, 4'd3, 8'h00, 8'h00, 1'b0);
        send_pkt(13'h300, 1'b0, 2'b01, 4'd3, 8'h00, 8'h00, 1'b1);
        send_pkt(13'h300, 1'b0, 2'b10, 4'd3, 8'h00, 8'h00, 1'b0);
        send_pkt(13'h300, 1'b0, 2'b01, 4'd4, 8'h00, 8'h00, 1'b0);
        idle(3);
        check_cnts("t3");

        // T4: discontinuity indicator, unflagged jump, other PIDs, null PID
        mon_pid = 13'h400;
        send_pkt(13'h400, 1'b0, 2'b01, 4'd2,  8'h00, 8'h00, 1'b0);
        send_pkt(13'h400, 1'b0, 2'b11, 4'd9,  8'h01, 8'h80, 1'b0);
        send_pkt(13'h400, 1'b0, 2'b01, 4'd10, 8'h00, 8'h00, 1'b0);
        send_pkt(13'h400, 1'b0, 2'b11, 4'd14, 8'h01, 8'h00, 1'b1);
        send_pkt(13'h123, 1'b0, 2'b01, 4'd7,  8'h00, 8'h00, 1'b0);
        send_pkt(13'h400, 1'b0, 2'b01, 4'd15, 8'h00, 8'h00, 1'b0);
        mon_pid = 13'h1FFF;
        send_pkt(13'h1FFF, 1'b0, 2'b01, 4'd0, 8'h00, 8'h00, 1'b0);
        send_pkt(13'h1FFF, 1'b0, 2'b01, 4'd5, 8'h00, 8'h00, 1'b0);
        send_pkt(13'h1FFF, 1'b0, 2'b01, 4'd9, 8'h00, 8'h00, 1'b0);
        idle(3);
        check_cnts("t4");

        // Reset mid-packet: asynchronous clear, then no parsing until sync
        send_byte(8'h47, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_async_pkt_cnt", 32'(pkt_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_pkt = 0; exp_tei = 0; exp_ccerr = 0; exp_loss = 0;
        for (int k = 0; k < 4; k++) send_byte(8'(k * 37), 1'b0, 1'b0);
        idle(3);
        check_cnts("rst_mid");

        // T5: early sync, then missing sync
        send_pkt(13'h055, 1'b0, 2'b01, 4'd1, 8'h00, 8'h00, 1'b0, 100);
        send_pkt(13'h056, 1'b0, 2'b01, 4'd2, 8'h00, 8'h00, 1'b0);
        exp_loss = sat(exp_loss);
        send_byte(8'h00, 1'b0, 1'b0);
        exp_loss = sat(exp_loss);
        for (int k = 0; k < 5; k++) send_byte(8'(k + 1), 1'b0, 1'b0);
        idle(3);
        check_cnts("t5");
        send_pkt(13'h057, 1'b0, 2'b01, 4'd3, 8'h00, 8'h00, 1'b0);
        idle(3);
        check_cnts("t5_relock");

        // T6: gapped stream, TEI counting, clear mid-packet and on a header cycle
        gap = 1'b1;
        send_pkt(13'h0AA, 1'b1, 2'b01, 4'd0, 8'h00, 8'h00, 1'b0);
        idle(3);
        check_cnts("t6_tei");
        send_pkt(13'h0AB, 1'b0, 2'b01, 4'd1, 8'h00, 8'h00, 1'b0, 188, 50);
        idle(3);
        check_cnts("t6_clr");
        send_pkt(13'h0AC, 1'b0, 2'b11, 4'd2, 8'h05, 8'h00, 1'b0);
        idle(3);
        check_cnts("t6_after");
        send_pkt(13'h0AD, 1'b1, 2'b01, 4'd3, 8'h00, 8'h00, 1'b0, 188, 3);
        idle(3);
        check_cnts("t6_clr_wins");
        gap = 1'b0;

        // T7: saturation of all counters but the CC one
        @(negedge clk);
        clr_cnt = 1'b1; byte_valid = 1'b0;
        @(negedge clk);
        clr_cnt = 1'b0;
        exp_pkt = 0; exp_tei = 0; exp_ccerr = 0; exp_loss = 0;
        for (int k = 0; k < 35; k++) begin
            send_pkt(13'h0AA, 1'b1, 2'b01, 4'(k), 8'h00, 8'h00, 1'b0, 8);
            if (k > 0) exp_loss = sat(exp_loss);
        end
        idle(3);
        check_cnts("t7_sat");
        chk("t7_pkt_cnt_max", 32'(pkt_cnt), 32'(CMAX));

        chk("hdr_pending", 32'(exp_hdr.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
